// File: rtl/nvdla_done_intr_gen_if.sv
// -----------------------------------------------------------------------------
// nvdla_done_intr_gen_if
// Signal bundle between one engine (with its DMA write channel) and the
// per-engine done-interrupt generator.
//   master : engine/DMA side. Drives the request/response handshake and the
//            layer-done marker. Observes the done pulse, busy and err.
//   slave  : interrupt generator side (the reverse directions).
// Signals:
//   dma_wr_req_vld / dma_wr_req_rdy : write issue handshake (issue = vld & rdy)
//   dma_wr_rsp_vld                  : one write-completion acknowledge
//   layer_done / layer_group        : end-of-layer marker and its register group
//   done_intr_pd[1:0]               : single-cycle done pulse, bit[g] = group g
//   busy, err                       : pending-layer flag, sticky protocol error
//   done_cnt0/1[7:0]                : per-group completion counters, present only
//                                     when NVDLA_DONE_INTR_CNT_EN is defined
// -----------------------------------------------------------------------------
interface nvdla_done_intr_gen_if;
    logic       dma_wr_req_vld;
    logic       dma_wr_req_rdy;
    logic       dma_wr_rsp_vld;
    logic       layer_done;
    logic       layer_group;
    logic [1:0] done_intr_pd;
    logic       busy;
    logic       err;
`ifdef NVDLA_DONE_INTR_CNT_EN
    logic [7:0] done_cnt0;
    logic [7:0] done_cnt1;
`endif

`ifdef NVDLA_DONE_INTR_CNT_EN
    modport master (
        output dma_wr_req_vld, dma_wr_req_rdy, dma_wr_rsp_vld, layer_done, layer_group,
        input  done_intr_pd, busy, err, done_cnt0, done_cnt1
    );
    modport slave (
        input  dma_wr_req_vld, dma_wr_req_rdy, dma_wr_rsp_vld, layer_done, layer_group,
        output done_intr_pd, busy, err, done_cnt0, done_cnt1
    );
`else
    modport master (
        output dma_wr_req_vld, dma_wr_req_rdy, dma_wr_rsp_vld, layer_done, layer_group,
        input  done_intr_pd, busy, err
    );
    modport slave (
        input  dma_wr_req_vld, dma_wr_req_rdy, dma_wr_rsp_vld, layer_done, layer_group,
        output done_intr_pd, busy, err
    );
`endif
endinterface

// File: rtl/nvdla_done_intr_gen.sv
// -----------------------------------------------------------------------------
// nvdla_done_intr_gen
// Per-engine done-interrupt generator. It counts outstanding DMA writes and
// queues up to two finished layers, one per ping-pong group. A layer's done
// pulse is emitted only once every write issued up to and including its
// layer_done cycle has been acknowledged.
// Ports:
//   nvdla_core_clk : core clock, rising edge
//   nvdla_core_rst : asynchronous active-high reset
//   intf           : nvdla_done_intr_gen_if.slave (handshakes, done pulse,
//                    busy, err)
// Parameter:
//   CNT_W          : width of the outstanding counter and of the entry counters
// Optional feature:
//   NVDLA_DONE_INTR_CNT_EN : adds the 8-bit per-group completion counters
//                            done_cnt0 / done_cnt1 on the interface.
// -----------------------------------------------------------------------------
module nvdla_done_intr_gen #(
    parameter int CNT_W = 14
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    nvdla_done_intr_gen_if.slave   intf
);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Entry counter after this cycle's acknowledge (never below zero).
    function automatic logic [CNT_W-1:0] dec_cnt(input logic [CNT_W-1:0] cnt,
                                                 input logic             rsp);
        if (rsp && (cnt != CNT_ZERO)) begin
            dec_cnt = cnt - CNT_ONE;
        end else begin
            dec_cnt = cnt;
        end
    endfunction

    logic             issue_s;
    logic             rsp_s;
    logic [CNT_W-1:0] outs_r;
    logic [CNT_W-1:0] outs_nxt_s;
    logic             outs_err_s;

    // Queue: entry 0 is the head; entry 1 valid implies entry 0 valid.
    logic             q0_v_r, q1_v_r;
    logic             q0_g_r, q1_g_r;
    logic [CNT_W-1:0] q0_c_r, q1_c_r;
    logic             nq0_v_s, nq1_v_s;
    logic             nq0_g_s, nq1_g_s;
    logic [CNT_W-1:0] nq0_c_s, nq1_c_s;

    // Three-slot view: existing entries in order, then the new push.
    logic [2:0]       slot_v_s;
    logic [2:0]       slot_g_s;
    logic [CNT_W-1:0] slot_c_s [3];

    logic             fire_a_s;
    logic             fire_b_s;
    logic             drop_s;
    logic             pp_err_s;
    logic [1:0]       pd_nxt_s;
    logic             busy_nxt_s;

    logic [1:0]       pd_r;
    logic             busy_r;
    logic             err_r;
    logic             last_grp_r;

    assign issue_s = intf.dma_wr_req_vld & intf.dma_wr_req_rdy;
    assign rsp_s   = intf.dma_wr_rsp_vld;

    // Outstanding-write counter next state with saturation / underflow detection.
    always_comb begin
        outs_nxt_s = outs_r;
        outs_err_s = 1'b0;
        case ({issue_s, rsp_s})
            2'b10: begin
                if (outs_r == CNT_MAX) begin
                    outs_err_s = 1'b1;
                end else begin
                    outs_nxt_s = outs_r + CNT_ONE;
                end
            end
            2'b01: begin
                if (outs_r == CNT_ZERO) begin
                    outs_err_s = 1'b1;
                end else begin
                    outs_nxt_s = outs_r - CNT_ONE;
                end
            end
            default: outs_nxt_s = outs_r;
        endcase
    end

    // Queue update: decrement, push, fire selection, pop and done-pulse generation.
    always_comb begin
        slot_v_s    = 3'b000;
        slot_g_s    = 3'b000;
        slot_c_s[0] = CNT_ZERO;
        slot_c_s[1] = CNT_ZERO;
        slot_c_s[2] = CNT_ZERO;
        nq0_v_s     = 1'b0;
        nq0_g_s     = 1'b0;
        nq0_c_s     = CNT_ZERO;
        nq1_v_s     = 1'b0;
        nq1_g_s     = 1'b0;
        nq1_c_s     = CNT_ZERO;
        pd_nxt_s    = 2'b00;

        slot_v_s[0] = q0_v_r;
        slot_g_s[0] = q0_g_r;
        slot_c_s[0] = dec_cnt(q0_c_r, rsp_s);
        slot_v_s[1] = q1_v_r;
        slot_g_s[1] = q1_g_r;
        slot_c_s[1] = dec_cnt(q1_c_r, rsp_s);

        // The new entry's count is the next-state outs, so a same-cycle issue
        // belongs to the finishing layer and a same-cycle rsp is already applied.
        if (intf.layer_done) begin
            if (!q0_v_r) begin
                slot_v_s[0] = 1'b1;
                slot_g_s[0] = intf.layer_group;
                slot_c_s[0] = outs_nxt_s;
            end else if (!q1_v_r) begin
                slot_v_s[1] = 1'b1;
                slot_g_s[1] = intf.layer_group;
                slot_c_s[1] = outs_nxt_s;
            end else begin
                slot_v_s[2] = 1'b1;
                slot_g_s[2] = intf.layer_group;
                slot_c_s[2] = outs_nxt_s;
            end
        end else begin
            slot_v_s[2] = 1'b0;
        end

        // Head fires at zero; the next one may join only for the other group.
        fire_a_s = slot_v_s[0] && (slot_c_s[0] == CNT_ZERO);
        fire_b_s = fire_a_s && slot_v_s[1] && (slot_c_s[1] == CNT_ZERO) &&
                   (slot_g_s[1] != slot_g_s[0]);

        // A full queue only accepts a push when the head pops this cycle.
        drop_s = intf.layer_done && q0_v_r && q1_v_r && !fire_a_s;
        if (drop_s) begin
            slot_v_s[2] = 1'b0;
        end else begin
            slot_v_s[2] = slot_v_s[2];
        end

        case ({fire_b_s, fire_a_s})
            2'b01: begin
                nq0_v_s = slot_v_s[1];
                nq0_g_s = slot_g_s[1];
                nq0_c_s = slot_c_s[1];
                nq1_v_s = slot_v_s[2];
                nq1_g_s = slot_g_s[2];
                nq1_c_s = slot_c_s[2];
            end
            2'b11: begin
                nq0_v_s = slot_v_s[2];
                nq0_g_s = slot_g_s[2];
                nq0_c_s = slot_c_s[2];
            end
            default: begin
                nq0_v_s = slot_v_s[0];
                nq0_g_s = slot_g_s[0];
                nq0_c_s = slot_c_s[0];
                nq1_v_s = slot_v_s[1];
                nq1_g_s = slot_g_s[1];
                nq1_c_s = slot_c_s[1];
            end
        endcase

        if (fire_a_s) begin
            pd_nxt_s[slot_g_s[0]] = 1'b1;
        end else begin
            pd_nxt_s = 2'b00;
        end
        if (fire_b_s) begin
            pd_nxt_s[slot_g_s[1]] = 1'b1;
        end else begin
            pd_nxt_s = pd_nxt_s;
        end
    end

    // A layer stays pending until its pulse has been driven, so busy covers the
    // pulse cycle and a repeat of the group whose pulse is in flight is flagged.
    assign busy_nxt_s = nq0_v_s | (pd_nxt_s != 2'b00);
    assign pp_err_s   = intf.layer_done && busy_r && (intf.layer_group == last_grp_r);

    // State registers: counter, queue, pulse, busy, sticky error, last pushed group.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            outs_r     <= CNT_ZERO;
            q0_v_r     <= 1'b0;
            q0_g_r     <= 1'b0;
            q0_c_r     <= CNT_ZERO;
            q1_v_r     <= 1'b0;
            q1_g_r     <= 1'b0;
            q1_c_r     <= CNT_ZERO;
            pd_r       <= 2'b00;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            last_grp_r <= 1'b0;
        end else begin
            outs_r     <= outs_nxt_s;
            q0_v_r     <= nq0_v_s;
            q0_g_r     <= nq0_g_s;
            q0_c_r     <= nq0_c_s;
            q1_v_r     <= nq1_v_s;
            q1_g_r     <= nq1_g_s;
            q1_c_r     <= nq1_c_s;
            pd_r       <= pd_nxt_s;
            busy_r     <= busy_nxt_s;
            err_r      <= err_r | outs_err_s | drop_s | pp_err_s;
            if (intf.layer_done && !drop_s) begin
                last_grp_r <= intf.layer_group;
            end
        end
    end

    assign intf.done_intr_pd = pd_r;
    assign intf.busy         = busy_r;
    assign intf.err          = err_r;

`ifdef NVDLA_DONE_INTR_CNT_EN
    logic [7:0] cnt0_r;
    logic [7:0] cnt1_r;

    // Per-group completion counters, stepping together with the done pulse.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            cnt0_r <= 8'd0;
            cnt1_r <= 8'd0;
        end else begin
            cnt0_r <= cnt0_r + {7'd0, pd_nxt_s[0]};
            cnt1_r <= cnt1_r + {7'd0, pd_nxt_s[1]};
        end
    end

    assign intf.done_cnt0 = cnt0_r;
    assign intf.done_cnt1 = cnt1_r;
`endif

endmodule
